// File: rtl/tcm_pipelined_controller.sv
// tcm_pipelined_controller: pipelined TCM on the femto core bus with fault checks and optional zero-fill init
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module tcm_pipelined_controller #(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 4096,
  parameter int LATENCY    = 1,
  parameter int INIT_ZERO  = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic                      w_rb,
  input  logic [`BUS_ACC_WIDTH-1:0] acc,
  input  logic [`BUS_WIDTH-1:0]     wdata,
  input  logic                      req,
  output logic [`BUS_WIDTH-1:0]     rdata,
  output logic                      resp,
  output logic                      fault,
  output logic                      ready
);
  localparam int IW = ADDR_WIDTH - 2;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [IW:0]   DEP  = (IW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] mem [DEPTH];
  logic [IW-1:0] idx;
  logic [AW-1:0] wv;
  logic [1:0] lane;
  logic is1, is2, is4, misalign, range_err, acc_ok;
  logic [3:0] be;
  logic [31:0] wsh, sh, rmask;
  logic nv, nr;
  logic [31:0] nd;
  assign idx = addr[ADDR_WIDTH-1:2];
  assign wv = idx[AW-1:0];
  assign lane = addr[1:0];
  assign is1 = acc == `BUS_ACC_1B;
  assign is2 = acc == `BUS_ACC_2B;
  assign is4 = acc == `BUS_ACC_4B;
  // lane 3 with 2B/4B is already caught by the odd-address term
  assign misalign = (lane[0] & ~is1) | (lane[1] & is4);
  assign range_err = {1'b0, idx} >= DEP;
  assign fault = req & (misalign | range_err | ~ready | ~(is1 | is2 | is4));
  assign acc_ok = req & ~fault;
  assign be = is1 ? 4'b0001 << lane : is2 ? 4'b0011 << {lane[1], 1'b0} : 4'hf;
  assign wsh = wdata << {lane, 3'b000};
  assign sh = mem[wv] >> {lane, 3'b000};
  assign rmask = is1 ? {24'b0, sh[7:0]} : is2 ? {16'b0, sh[15:0]} : sh;
  always_ff @(posedge clk) begin
    if (state == INIT) mem[cnt[AW-1:0]] <= '0;
    else if (acc_ok & w_rb)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[wv][8*b +: 8] <= wsh[8*b +: 8];
  end
  // the final pipeline stage is the resp/rdata register itself
  generate
    if (LATENCY == 1) begin : g_direct
      assign nv = acc_ok;
      assign nr = ~w_rb;
      assign nd = rmask;
    end else begin : g_pipe
      logic [LATENCY-2:0] pv, pr;
      logic [31:0] pd [LATENCY-1];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          pv <= '0;
          pr <= '0;
        end else begin
          pv[0] <= acc_ok;
          pr[0] <= ~w_rb;
          for (int i = 1; i < LATENCY - 1; i++) begin
            pv[i] <= pv[i-1];
            pr[i] <= pr[i-1];
          end
        end
      end
      always_ff @(posedge clk) begin
        pd[0] <= rmask;
        for (int i = 1; i < LATENCY - 1; i++) pd[i] <= pd[i-1];
      end
      assign nv = pv[LATENCY-2];
      assign nr = pr[LATENCY-2];
      assign nd = pd[LATENCY-2];
    end
  endgenerate
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= INIT_ZERO != 0 ? INIT : RUN;
      ready <= INIT_ZERO == 0;
      cnt   <= '0;
      resp  <= 1'b0;
      rdata <= '0;
    end else begin
      if (state == INIT) begin
        cnt <= cnt + CW'(1);
        if (cnt == LAST) begin
          state <= RUN;
          ready <= 1'b1;
        end
      end
      resp <= nv;
      if (nv & nr) rdata <= nd;
    end
  end
endmodule

// File: tb/tb_tcm_pipelined_controller.sv
// tb_tcm_pipelined_controller: scoreboard bench for a LATENCY=3 zero-init instance and a LATENCY=1 no-init instance
module tb_tcm_pipelined_controller;
  localparam logic [1:0] A1 = 2'd0, A2 = 2'd1, A4 = 2'd2, AX = 2'd3;
  typedef struct {bit rd; logic [31:0] d; int due;} exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] rstn, req, w_rb, resp, fault, ready;
  logic [15:0] addr [2];
  logic [1:0] acc [2];
  logic [31:0] wdata [2], rdata [2], last_rd [2];
  int total = 0, bad = 0, cyc = 0;
  exp_t q0[$], q1[$];

  tcm_pipelined_controller #(.ADDR_WIDTH(16), .DEPTH(16), .LATENCY(3), .INIT_ZERO(1)) u0 (
    .clk(clk), .rstn(rstn[0]), .addr(addr[0]), .w_rb(w_rb[0]), .acc(acc[0]), .wdata(wdata[0]),
    .req(req[0]), .rdata(rdata[0]), .resp(resp[0]), .fault(fault[0]), .ready(ready[0]));
  tcm_pipelined_controller #(.ADDR_WIDTH(16), .DEPTH(16), .LATENCY(1), .INIT_ZERO(0)) u1 (
    .clk(clk), .rstn(rstn[1]), .addr(addr[1]), .w_rb(w_rb[1]), .acc(acc[1]), .wdata(wdata[1]),
    .req(req[1]), .rdata(rdata[1]), .resp(resp[1]), .fault(fault[1]), .ready(ready[1]));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic issue(int d, logic [15:0] a, logic w, logic [1:0] ac, logic [31:0] wd, logic f, logic [31:0] ed);
    exp_t e;
    addr[d] = a; w_rb[d] = w; acc[d] = ac; wdata[d] = wd; req[d] = 1'b1;
    #2 chk($sformatf("fault dut%0d @%h", d, a), {31'b0, fault[d]}, {31'b0, f});
    if (!f) begin
      e.rd = !w; e.d = ed; e.due = cyc + (d == 0 ? 3 : 1);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk);
    #1 req[d] = 1'b0;
  endtask

  task automatic wait_ready(int n0, int exp);
    int n = n0;
    while (!ready[0] && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("init_cycles", n, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++)
      if (resp[d] === 1'b1) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp dut%0d: got resp=1 expected none at cycle %0d", d, cyc);
        end else begin
          if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
          chk($sformatf("resp_cycle dut%0d", d), cyc, e.due);
          chk($sformatf("%s dut%0d", e.rd ? "rdata" : "rdata_hold", d), rdata[d], e.rd ? e.d : last_rd[d]);
          if (e.rd) last_rd[d] = e.d;
        end
      end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rstn = 2'b00; req = 2'b00; w_rb = 2'b00;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; acc[d] = A4; wdata[d] = '0; last_rd[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("u0_ready_in_reset", {31'b0, ready[0]}, 0);
    chk("u1_ready_in_reset", {31'b0, ready[1]}, 1);
    chk("u0_resp_in_reset", {31'b0, resp[0]}, 0);
    chk("u0_rdata_in_reset", rdata[0], 0);
    rstn[0] = 1'b1;
    issue(0, 16'h0000, 0, A4, 0, 1, 0);
    wait_ready(1, 16);
    issue(0, 16'h003C, 0, A4, 0, 0, 32'h0);
    issue(0, 16'h0010, 1, A4, 32'hDEADBEEF, 0, 0);
    issue(0, 16'h0010, 0, A4, 0, 0, 32'hDEADBEEF);
    issue(0, 16'h0013, 0, A1, 0, 0, 32'h000000DE);
    issue(0, 16'h0012, 0, A2, 0, 0, 32'h0000DEAD);
    issue(0, 16'h0020, 1, A4, 32'h11223344, 0, 0);
    issue(0, 16'h0021, 1, A1, 32'h000000AA, 0, 0);
    issue(0, 16'h0020, 0, A4, 0, 0, 32'h1122AA44);
    issue(0, 16'h0022, 1, A2, 32'h00005566, 0, 0);
    issue(0, 16'h0020, 0, A4, 0, 0, 32'h5566AA44);
    issue(0, 16'h0001, 1, A2, 32'hFFFFFFFF, 1, 0);
    issue(0, 16'h0002, 1, A4, 32'hFFFFFFFF, 1, 0);
    issue(0, 16'h0003, 1, A2, 32'hFFFFFFFF, 1, 0);
    issue(0, 16'h0040, 1, A4, 32'hFFFFFFFF, 1, 0);
    issue(0, 16'h0040, 0, A1, 0, 1, 0);
    issue(0, 16'h0020, 1, AX, 32'hFFFFFFFF, 1, 0);
    issue(0, 16'h0000, 0, A4, 0, 0, 32'h0);
    issue(0, 16'h0020, 0, A4, 0, 0, 32'h5566AA44);
    issue(0, 16'h003C, 1, A4, 32'hCAFEF00D, 0, 0);
    issue(0, 16'h003E, 0, A2, 0, 0, 32'h0000CAFE);
    issue(0, 16'h0010, 0, A4, 0, 0, 32'hDEADBEEF);
    issue(0, 16'h0020, 0, A4, 0, 0, 32'h5566AA44);
    @(posedge clk);
    #1 rstn[0] = 1'b0;
    #1;
    chk("midflight_rst_resp", {31'b0, resp[0]}, 0);
    chk("midflight_rst_rdata", rdata[0], 0);
    q0.delete();
    last_rd[0] = '0;
    repeat (2) @(posedge clk);
    #1 rstn[0] = 1'b1;
    wait_ready(0, 16);
    issue(0, 16'h0010, 0, A4, 0, 0, 32'h0);
    rstn[1] = 1'b1;
    issue(1, 16'h0004, 1, A4, 32'h12345678, 0, 0);
    issue(1, 16'h0004, 0, A4, 0, 0, 32'h12345678);
    issue(1, 16'h0005, 0, A1, 0, 0, 32'h00000056);
    issue(1, 16'h0006, 0, A2, 0, 0, 32'h00001234);
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("drain", q0.size() + q1.size(), 0);
    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
